// File: rtl/pair_loader.sv
// pair_loader: packs a serial byte stream into {A,B} operand pairs and offers each pair on a
// valid/ready handshake. Defining PAIR_CNT_EN adds the pair_cnt delivered-pair counter port.
module pair_loader #(
    parameter int W = 8
`ifdef PAIR_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [W-1:0]     out_A,
    output logic [W-1:0]     out_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             odd_err
`ifdef PAIR_CNT_EN
    ,
    output logic [CNT_W-1:0] pair_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           out_valid_q, out_valid_d;
    logic           odd_err_q, odd_err_d;
    logic           in_xfer_s;
    logic           out_xfer_s;
`ifdef PAIR_CNT_EN
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
`endif

    // Next-state and capture logic; flush never blocks a pending out_xfer of a full pair.
    always_comb begin
        in_ready    = !flush && ((state_q != ST_FULL) || out_ready);
        in_xfer_s   = in_valid && in_ready;
        out_xfer_s  = out_valid_q && out_ready;
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        odd_err_d   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_d = ST_HALF;
                    a_d     = in_data;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_HALF: begin
                if (flush) begin
                    state_d   = ST_EMPTY;
                    odd_err_d = 1'b1;
                end else if (in_xfer_s) begin
                    state_d = ST_FULL;
                    b_d     = in_data;
                end else begin
                    state_d = ST_HALF;
                end
            end
            ST_FULL: begin
                if (out_xfer_s && in_xfer_s) begin
                    state_d = ST_HALF;
                    a_d     = in_data;
                end else if (out_xfer_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        out_valid_d = (state_d == ST_FULL);
`ifdef PAIR_CNT_EN
        if (out_xfer_s) begin
            pair_cnt_d = pair_cnt_q + CNT_W'(1);
        end else begin
            pair_cnt_d = pair_cnt_q;
        end
`endif
    end

    // State and output registers; reset overrides flush and any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            out_valid_q <= 1'b0;
            odd_err_q   <= 1'b0;
`ifdef PAIR_CNT_EN
            pair_cnt_q  <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            odd_err_q   <= odd_err_d;
`ifdef PAIR_CNT_EN
            pair_cnt_q  <= pair_cnt_d;
`endif
        end
    end

    assign out_A     = a_q;
    assign out_B     = b_q;
    assign out_valid = out_valid_q;
    assign odd_err   = odd_err_q;
`ifdef PAIR_CNT_EN
    assign pair_cnt  = pair_cnt_q;
`endif

endmodule

// File: tb/tb_pair_loader.sv
// Self-checking bench for pair_loader: directed vector table, hand-written streaming and
// counter-wrap sequences, then random traffic against a byte-count reference model.
module tb_pair_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [7:0] out_A;
    logic [7:0] out_B;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       odd_err;
`ifdef PAIR_CNT_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] pair_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: number of bytes held plus the two byte slots.
    int         m_held = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic       m_odd = 1'b0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    pair_loader #(
        .W(8)
`ifdef PAIR_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_A(out_A),
        .out_B(out_B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .odd_err(odd_err)
`ifdef PAIR_CNT_EN
        , .pair_cnt(pair_cnt)
`endif
    );

    typedef struct {
        logic       rs;
        logic       iv;
        logic [7:0] d;
        logic       fl;
        logic       orr;
        logic       chk_ir;
        logic       ir;
        logic       ov;
        logic [7:0] a;
        logic [7:0] b;
        logic       odd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic bit m_ready(input bit fl, input bit orr);
        return !fl && ((m_held != 2) || orr);
    endfunction

    task automatic model_step(input bit rs, input bit iv, input logic [7:0] d, input bit fl, input bit orr);
        bit rdy;
        bit inx;
        bit outx;
        rdy  = m_ready(fl, orr);
        inx  = iv && rdy;
        outx = (m_held == 2) && orr;
        if (rs) begin
            m_held = 0; m_a = 8'h00; m_b = 8'h00; m_odd = 1'b0; m_cnt = 0;
        end else begin
            m_odd = fl && (m_held == 1);
            if (outx) begin
                m_held = 0;
                m_cnt++;
            end
            if (m_odd) m_held = 0;
            if (inx) begin
                if (m_held == 0) m_a = d;
                else m_b = d;
                m_held++;
            end
        end
    endtask

    // One cycle checked against the reference model.
    task automatic cyc(input int idx, input bit rs, input bit iv, input logic [7:0] d, input bit fl, input bit orr);
        rst = rs; in_valid = iv; in_data = d; flush = fl; out_ready = orr;
        #1;
        chk("in_ready", idx, {31'd0, in_ready}, {31'd0, m_ready(fl, orr)});
        @(posedge clk);
        model_step(rs, iv, d, fl, orr);
        #1;
        chk("out_valid", idx, {31'd0, out_valid}, {31'd0, (m_held == 2)});
        chk("out_A", idx, {24'd0, out_A}, {24'd0, m_a});
        chk("out_B", idx, {24'd0, out_B}, {24'd0, m_b});
        chk("odd_err", idx, {31'd0, odd_err}, {31'd0, m_odd});
`ifdef PAIR_CNT_EN
        chk("pair_cnt", idx, {28'd0, pair_cnt}, m_cnt % (1 << CNT_W));
`endif
    endtask

    initial begin
        // rs iv d fl orr chk_ir ir ov a b odd
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h22, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h44, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'h44, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h44, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h44, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hBB, 8'h44, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBB, 8'hCC, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hBB, 8'hCC, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hDD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hBB, 8'hCC, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hBB, 8'hCC, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE, 8'hCC, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});

        foreach (tbl[i]) begin
            rst = tbl[i].rs; in_valid = tbl[i].iv; in_data = tbl[i].d;
            flush = tbl[i].fl; out_ready = tbl[i].orr;
            #1;
            if (tbl[i].chk_ir) chk("tbl_in_ready", i, {31'd0, in_ready}, {31'd0, tbl[i].ir});
            @(posedge clk);
            model_step(tbl[i].rs, tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].orr);
            #1;
            chk("tbl_out_valid", i, {31'd0, out_valid}, {31'd0, tbl[i].ov});
            chk("tbl_out_A", i, {24'd0, out_A}, {24'd0, tbl[i].a});
            chk("tbl_out_B", i, {24'd0, out_B}, {24'd0, tbl[i].b});
            chk("tbl_odd_err", i, {31'd0, odd_err}, {31'd0, tbl[i].odd});
        end

        // Streaming 0x01..0x08 with the consumer always ready.
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            cyc(100 + k, 1'b0, 1'b1, kb, 1'b0, 1'b1);
            chk("stream_ov", k, {31'd0, out_valid}, {31'd0, (k % 2 == 0)});
            if (k % 2 == 0) begin
                chk("stream_A", k, {24'd0, out_A}, {24'd0, kb - 8'd1});
                chk("stream_B", k, {24'd0, out_B}, {24'd0, kb});
            end else begin
                chk("stream_A", k, {24'd0, out_A}, {24'd0, kb});
            end
        end
        cyc(109, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

`ifdef PAIR_CNT_EN
        // Deliver 17 pairs into a 4-bit counter to cross the wrap.
        cyc(200, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(201, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int p = 1; p <= 17; p++) begin
            cyc(300 + p, 1'b0, 1'b1, 8'(2 * p), 1'b0, 1'b1);
            cyc(300 + p, 1'b0, 1'b1, 8'(2 * p + 1), 1'b0, 1'b1);
            cyc(300 + p, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            if (p == 15) chk("cnt_15", p, {28'd0, pair_cnt}, 32'd15);
            if (p == 16) chk("cnt_wrap", p, {28'd0, pair_cnt}, 32'd0);
            if (p == 17) chk("cnt_17", p, {28'd0, pair_cnt}, 32'd1);
        end
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            bit rs;
            bit fl;
            bit iv;
            bit orr;
            logic [7:0] d;
            rs  = ($urandom_range(0, 49) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            d   = 8'($urandom);
            cyc(1000 + n, rs, iv, d, fl, orr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
